// File: rtl/buf_arb_pkg.sv
// Shared types and helpers for the BUF request arbiter.
package buf_arb_pkg;

    // Handshake phases of one forwarded transfer
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        HOLD = 2'd2,
        REL  = 2'd3
    } state_t;

    localparam int XCNT_W  = 16;
    localparam int MAX_SRC = 8;

    // Round-robin winner: first set bit of req searching last+1, last+2, ...
    // modulo n. Returns 0 when nothing is requested (caller qualifies with any-req).
    function automatic int rr_pick(input logic [MAX_SRC-1:0] req,
                                   input int last,
                                   input int n = MAX_SRC);
        int idx;
        bit found;
        rr_pick = 0;
        found   = 1'b0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            if (k <= n && !found) begin
                idx = last + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[2:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: request vector plus last winner in,
// next winner and any-request flag out. Reusable by other schedulers.
module rr_priority_pick
    import buf_arb_pkg::*;
#(
    parameter int N   = 3,
    parameter int IDW = $clog2(N)
)(
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [IDW-1:0] winner,
    output logic           anyReq
);

    logic [MAX_SRC-1:0] reqExt;

    // Widen to the helper's fixed width and pick the next requester after last
    always_comb begin
        reqExt         = '0;
        reqExt[N-1:0]  = req;
        winner         = IDW'(rr_pick(reqExt, int'(last), N));
        anyReq         = |req;
    end

endmodule

// File: rtl/buf_req_arbiter.sv
// Round-robin arbiter sharing one four-phase REQ/ACK BUF port between
// NUM_SRC senders. Grants are held for a full handshake; a watchdog flags
// a BUF that stalls on either acknowledge edge.
module buf_req_arbiter
    import buf_arb_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         s_req,
    input  logic [NUM_SRC*DATA_W-1:0]  s_data,
    output logic [NUM_SRC-1:0]         s_ack,
    output logic                       b_req,
    output logic [DATA_W-1:0]          b_data,
    input  logic                       b_ack,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic [XCNT_W-1:0]          xfer_count,
    output logic                       timeout_err
);

    localparam int IDW = $clog2(NUM_SRC);
    localparam logic [XCNT_W-1:0] TO_LIM = XCNT_W'(TIMEOUT);

    state_t            state;
    logic [IDW-1:0]    lastGrant;
    logic [IDW-1:0]    winner;
    logic              anyReq;
    logic [XCNT_W-1:0] wdCnt;
    logic              stall;

    rr_priority_pick #(
        .N   (NUM_SRC),
        .IDW (IDW)
    ) uPick (
        .req    (s_req),
        .last   (lastGrant),
        .winner (winner),
        .anyReq (anyReq)
    );

    // Handshake FSM; every output is registered here. Other senders' requests
    // are only looked at in IDLE, so a grant cannot be stolen mid-transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lastGrant  <= IDW'(NUM_SRC - 1);
            grant_id   <= '0;
            s_ack      <= '0;
            b_req      <= 1'b0;
            b_data     <= '0;
            busy       <= 1'b0;
            xfer_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        grant_id <= winner;
                        b_data   <= s_data[int'(winner)*DATA_W +: DATA_W];
                        b_req    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= FWD;
                    end
                end
                FWD: begin
                    if (b_ack) begin
                        s_ack <= NUM_SRC'(1) << grant_id;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    // A sender that dropped early (during FWD) exits here at once
                    if (!s_req[grant_id]) begin
                        b_req <= 1'b0;
                        state <= REL;
                    end
                end
                REL: begin
                    if (!b_ack) begin
                        s_ack      <= '0;
                        lastGrant  <= grant_id;
                        xfer_count <= xfer_count + XCNT_W'(1);
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Waiting on a BUF acknowledge edge: FWD without ack rise, REL without ack fall.
    // Every other cycle either changes state or waits on the sender, so the
    // watchdog count restarts.
    assign stall = ((state == FWD) && !b_ack) || ((state == REL) && b_ack);

    // Watchdog: count stalled cycles, saturate at the limit, latch the sticky flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdCnt       <= '0;
            timeout_err <= 1'b0;
        end else if (!stall) begin
            wdCnt <= '0;
        end else if (wdCnt != TO_LIM) begin
            wdCnt <= wdCnt + XCNT_W'(1);
            if ((wdCnt + XCNT_W'(1)) == TO_LIM) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_buf_req_arbiter.sv
// Directed bench for buf_req_arbiter with sender/BUF agents, a transfer-level
// reference model checked every cycle, and hand-computed literal checks.
module tb_buf_req_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk;
    logic          rst = 1'b0;
    logic [N-1:0]  s_req = '0;
    logic [N*DW-1:0] s_data = '0;
    logic          b_ack = 1'b0;
    logic [N-1:0]  s_ack;
    logic          b_req;
    logic [DW-1:0] b_data;
    logic [1:0]    grant_id;
    logic          busy;
    logic [15:0]   xfer_count;
    logic          timeout_err;

    buf_req_arbiter #(.NUM_SRC(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .s_req(s_req), .s_data(s_data), .s_ack(s_ack),
        .b_req(b_req), .b_data(b_data), .b_ack(b_ack), .grant_id(grant_id),
        .busy(busy), .xfer_count(xfer_count), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errs   = 0;
    int want[N];
    int done[N];
    bit bufHold = 1'b0, hang = 1'b0, earlyDrop = 1'b0;
    int glog[$];
    bit prevBreq = 1'b0;
    int bCnt = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] sdat(input int i, input int n);
        return DW'(5 + (i << 8) + (n << 12));
    endfunction

    // ---------------- transfer-level reference model ----------------
    bit mBusy, mAcked, mBReq, mErr;
    int mG, mLast, mWait, mCnt;
    logic [DW-1:0] mData;

    task automatic modelReset();
        mBusy = 0; mAcked = 0; mBReq = 0; mErr = 0;
        mG = 0; mLast = N - 1; mWait = 0; mCnt = 0; mData = '0;
    endtask

    task automatic modelStep();
        bit stalled;
        stalled = 0;
        if (!mBusy) begin
            if (|s_req) begin
                for (int k = 1; k <= N; k++) begin
                    if (!mBusy && s_req[(mLast + k) % N]) begin
                        mG = (mLast + k) % N;
                        mBusy = 1;
                    end
                end
                mData = s_data[mG*DW +: DW];
                mBReq = 1;
            end
        end else if (mBReq && !mAcked) begin
            if (b_ack) mAcked = 1; else stalled = 1;
        end else if (mBReq && mAcked) begin
            if (!s_req[mG]) mBReq = 0;
        end else begin
            if (!b_ack) begin
                mAcked = 0; mBusy = 0; mLast = mG; mCnt = (mCnt + 1) % 65536;
            end else stalled = 1;
        end
        if (stalled) begin
            if (mWait < TO) mWait++;
            if (mWait == TO) mErr = 1;
        end else mWait = 0;
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) modelReset(); else modelStep();
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("b_req", b_req, mBReq);
            chk("b_data", b_data, mData);
            chk("s_ack", s_ack, mAcked ? (64'd1 << mG) : 64'd0);
            chk("grant_id", grant_id, mG);
            chk("busy", busy, mBusy);
            chk("xfer_count", xfer_count, mCnt);
            chk("timeout_err", timeout_err, mErr);
        end
    end

    // ---------------- agents ----------------
    // Senders: raise when work is pending, drop on ack (or early if asked)
    initial begin
        forever begin
            @(negedge clk);
            if (rst) s_req = '0;
            else begin
                for (int i = 0; i < N; i++) begin
                    if (s_req[i] && s_ack[i] && !hang) begin
                        s_req[i] = 1'b0; done[i]++;
                    end else if (s_req[i] && earlyDrop && i == 2 && b_req &&
                                 int'(grant_id) == i && !s_ack[i]) begin
                        s_req[i] = 1'b0; done[i]++;
                    end else if (!s_req[i] && !s_ack[i] && done[i] < want[i]) begin
                        s_data[i*DW +: DW] = sdat(i, done[i]);
                        s_req[i] = 1'b1;
                    end
                end
            end
        end
    end

    // BUF: ack two samples after req, release ack once req falls
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin b_ack = 0; bCnt = 0; end
            else if (b_req && !b_ack) begin
                if (!bufHold) begin
                    bCnt++;
                    if (bCnt >= 2) b_ack = 1;
                end
            end else if (!b_req) begin
                b_ack = 0; bCnt = 0;
            end
        end
    end

    // Grant order log: one entry per b_req rise
    initial begin
        forever begin
            @(negedge clk);
            if (b_req && !prevBreq) glog.push_back(int'(grant_id));
            prevBreq = b_req;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic bit allDone();
        for (int i = 0; i < N; i++) if (done[i] != want[i]) return 0;
        return !busy && !b_req && (s_ack == '0);
    endfunction

    task automatic waitDone(input string nm);
        bit ok;
        ok = 0;
        for (int t = 0; t < 400 && !ok; t++) begin
            tick();
            if (allDone()) ok = 1;
        end
        if (!ok) begin
            checks++; errs++;
            $display("FAIL %s: still busy after 400 cycles, required idle", nm);
        end
    endtask

    task automatic chkLog(input string nm, input int n, input logic [31:0] e);
        chk({nm, "_len"}, glog.size(), n);
        for (int k = 0; k < n && k < glog.size(); k++) chk(nm, glog[k], e[k*4 +: 4]);
    endtask

    task automatic doReset();
        tick();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // ---------------- directed sequence ----------------
    int base;
    initial begin
        #1 rst = 1;
        repeat (2) tick();
        chk("rst_breq", b_req, 0);
        chk("rst_sack", s_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_xfer", xfer_count, 0);
        rst = 0;
        tick();

        // Single requester: 1-cycle req->b_req, 1-cycle b_ack->s_ack
        want[0]++;
        tick();
        chk("single_breq_lat0", b_req, 0);
        tick();
        chk("single_breq", b_req, 1);
        chk("single_data", b_data, 32'h5);
        chk("single_gid", grant_id, 0);
        for (int t = 0; t < 20 && !b_ack; t++) tick();
        chk("single_sack_lat0", s_ack, 0);
        tick();
        chk("single_sack", s_ack, 3'b001);
        waitDone("single");
        chk("single_xfer", xfer_count, 1);

        // Fairness from a fresh reset
        doReset();
        glog.delete();
        for (int i = 0; i < N; i++) want[i] += 2;
        waitDone("fair");
        chkLog("fair", 6, 32'h210210);
        chk("fair_xfer", xfer_count, 6);

        // Rotation: after a grant to 1, {0,1} requesting goes to 0
        want[1]++;
        waitDone("rot_pre");
        glog.delete();
        want[0]++; want[1]++;
        waitDone("rot");
        chkLog("rot", 2, 32'h10);

        // Early drop by sender 2 during FWD
        earlyDrop = 1;
        base = int'(xfer_count);
        glog.delete();
        want[2]++;
        begin
            int hc;
            hc = 0;
            for (int t = 0; t < 100 && !allDone(); t++) begin
                tick();
                if (s_ack[2] && b_req) hc++;
            end
            chk("drop_hold_cycles", hc, 1);
        end
        chk("drop_xfer", xfer_count, base + 1);
        chkLog("drop", 1, 32'h2);
        earlyDrop = 0;

        // Timeout: BUF never acks until released
        bufHold = 1;
        base = int'(xfer_count);
        want[0]++;
        for (int t = 0; t < 20 && !b_req; t++) tick();
        chk("to_breq", b_req, 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) chk("to_err_early", timeout_err, 0);
            if (k == 8) chk("to_err_set", timeout_err, 1);
        end
        repeat (3) tick();
        chk("to_err_hold", timeout_err, 1);
        bufHold = 0;
        waitDone("to");
        chk("to_err_sticky", timeout_err, 1);
        chk("to_xfer", xfer_count, base + 1);

        // Reset while in HOLD (last completed grant was 0)
        hang = 1;
        want[0]++;
        for (int t = 0; t < 30 && !s_ack[0]; t++) tick();
        chk("rst_hold_sack", s_ack, 3'b001);
        #2 rst = 1;
        #1;
        chk("rst_async_sack", s_ack, 0);
        chk("rst_async_breq", b_req, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_err", timeout_err, 0);
        want[2]++;
        hang = 0;
        glog.delete();
        tick();
        rst = 0;
        waitDone("post_rst");
        chkLog("post_rst", 2, 32'h20);
        chk("post_rst_xfer", xfer_count, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule

// File: doc/buf_req_arbiter.md
Name: buf_req_arbiter

Overview:
- Round-robin arbiter that shares one BUF-style four-phase REQ/ACK data port between NUM_SRC senders.
- Sits between several Sender-type producers and a single BUF instance.
- Forwards the granted sender's data and request downstream, and relays the acknowledge back to that sender.
- Provides transfer counting and a sticky handshake-timeout flag for the Checker/monitor layer.

Parameters:
- NUM_SRC, 3, number of senders, 2..8.
- DATA_W, 32, data width per sender.
- TIMEOUT, 64, cycles allowed waiting on b_ack edges before timeout_err sets; 1..65535.

Ports:
- clk  input  1  sole clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- s_req  input  NUM_SRC  per-sender request, synchronous to clk.
- s_data  input  NUM_SRC*DATA_W  sender i data at bits [i*DATA_W +: DATA_W]; held stable while s_req[i]=1.
- s_ack  output  NUM_SRC  per-sender acknowledge, one-hot or zero.
- b_req  output  1  request to BUF.
- b_data  output  DATA_W  data to BUF, registered.
- b_ack  input  1  acknowledge from BUF.
- grant_id  output  $clog2(NUM_SRC)  index of the current or last granted sender.
- busy  output  1  high whenever state != IDLE.
- xfer_count  output  16  completed transfers; wraps 65535->0.
- timeout_err  output  1  sticky handshake-timeout flag.

Behaviour:
- Reset values (asynchronous, all outputs registered):
  - s_ack=0, b_req=0, b_data=0, grant_id=0, busy=0, xfer_count=0, timeout_err=0.
  - state=IDLE; last_grant=NUM_SRC-1, so sender 0 has first priority.
- IDLE:
  - If any s_req bit is set, the winner is the first set bit searching last_grant+1, +2, ... modulo NUM_SRC.
  - Same edge: grant_id<=winner, b_data<=s_data[winner], b_req<=1, go to FWD.
  - Latency from s_req high to b_req high is 1 cycle.
- FWD:
  - On b_ack=1: s_ack[grant_id]<=1, go to HOLD. Latency from b_ack to s_ack is 1 cycle.
- HOLD:
  - On s_req[grant_id]=0: b_req<=0, go to REL.
- REL:
  - On b_ack=0: s_ack[grant_id]<=0, last_grant<=grant_id, xfer_count<=xfer_count+1, go to IDLE.
  - A new grant can issue on the next edge, so the minimum gap between transfers is 1 IDLE cycle.
- Sender requests are never re-sampled mid-transfer:
  - A grant is held until REL completes.
  - If s_req[grant_id] drops while in FWD (protocol violation), the transfer still completes; HOLD then exits on its first cycle.
- Requests from other senders are ignored while busy=1; they wait for the next arbitration.
- Simultaneous requests are resolved purely by the round-robin order above. With all senders requesting continuously, grants rotate 0,1,2,0,...
- b_data changes only on the IDLE->FWD edge and is held otherwise.
- Watchdog:
  - A 16-bit counter clears on every state change and increments each cycle spent in FWD or REL.
  - When the counter reaches TIMEOUT, timeout_err<=1. The counter saturates there.
  - The FSM keeps waiting; there is no abort.
  - timeout_err clears only on rst.
- Reset mid-transfer: all outputs return to their reset values immediately; any transfer in flight is abandoned.

Decomposition:
- Package buf_arb_pkg:
  - state enum IDLE=2'd0, FWD=2'd1, HOLD=2'd2, REL=2'd3;
  - constant XCNT_W=16;
  - function rr_pick(req, last) returning the winner index.
- Sub-module rr_priority_pick: combinational round-robin selector (req vector, last_grant -> winner, any_req). It is shared with future multi-receiver schedulers.
- FSM, datapath mux, counters and watchdog stay in buf_req_arbiter.

Test Plan:
- Single requester: s_req=3'b001, s_data[0]=32'h5; BUF model acks 2 cycles after b_req.
  - Expect b_req high 1 cycle after s_req, b_data=5, grant_id=0.
  - Expect s_ack[0] 1 cycle after b_ack; xfer_count=1 after b_ack falls.
- Fairness: s_req=3'b111 held continuously, with each sender re-raising req after its ack drops.
  - Expect grant order 0,1,2,0,1,2 over 6 transfers and xfer_count=6.
- Priority rotation: after a grant to 1, s_req=3'b011.
  - Expect grant to 0, not 1.
- Timeout: TIMEOUT=8, b_ack held at 0 after b_req.
  - Expect timeout_err=1 exactly 8 cycles after entering FWD.
  - Then raise b_ack: expect the transfer to complete normally with timeout_err still 1.
- Reset mid-op: assert rst in HOLD.
  - Expect s_ack=0, b_req=0, busy=0 without waiting for a clock edge.
  - After release, the first grant goes to sender 0.
- Early drop: s_req[2] falls while in FWD.
  - Expect the transfer to complete, HOLD to last 1 cycle, and xfer_count to increment by 1.
